subcounter: RTL and testbench
=============================

# subcounter

Single `granularity`-bit counter slice, the building block of the shared counter array. The parent controller chains several slices to form wider logical counters and drives each slice independently:
- a 2-bit command (reset / increment / idle);
- a parallel-load strobe with load data.

The slice holds its value in a register and presents it continuously on `data_out`. All carry, chaining and allocation logic lives in the parent, not here.

## Interface
- `granularity`, default 4: width in bits of the counter value; legal range ≥ 1.

- `clk`  input  1  single clock; all state updates on its rising edge.
- `rst`  input  1  reset, asynchronous, active-low. Low forces `data_out` to 0 immediately.
- `sub_command_in`  input  2  command:
  - 2'b00 = synchronous clear;
  - 2'b01 = increment;
  - 2'b10 = idle/hold;
  - 2'b11 = reserved, treated as hold.
- `load_data_in`  input  `granularity`  parallel load value; sampled only when `load_en`=1.
- `load_en`  input  1  parallel load strobe, active-high.
- `data_out`  output  `granularity`  current counter value, registered.

## Operation
- Single register `value[granularity-1:0]`; `data_out` = `value` directly. No combinational path from inputs to `data_out`.
- Priority per rising edge of `clk`, highest first:
  1. `rst`=0 (asynchronous, overrides everything): `value` ← 0.
  2. `load_en`=1: `value` ← `load_data_in`, regardless of `sub_command_in`.
  3. `sub_command_in`=2'b00: `value` ← 0.
  4. `sub_command_in`=2'b01: `value` ← `value`+1, modulo 2^`granularity`; all-ones wraps to 0.
  5. `sub_command_in`=2'b10 or 2'b11: `value` unchanged.
- Increment is plain unsigned binary. The slice generates no carry output:
  - the parent detects all-ones on `data_out` and issues clear to this slice and increment to the next slice itself;
  - self-wrap on increment-at-all-ones yields the same result as the parent's clear.
- X/undefined `sub_command_in` while `load_en`=0 and `rst`=1 holds the value; no X propagation into `value` for encodings 2'b11.
- No internal state other than `value`; no FSM.

## Timing
- Reset value: `data_out` = 0, asserted asynchronously as soon as `rst` falls, held while `rst`=0.
- Release of `rst` takes effect synchronously; the first update occurs on the first rising edge with `rst`=1.
- Latency: every command and load is visible on `data_out` exactly one cycle later, i.e. after the rising edge at which it was sampled.
- Commands are level-sampled each cycle with no handshake. Holding 2'b01 for k cycles advances `value` by k (mod 2^`granularity`).
- Simultaneous `load_en`=1 and any command: load wins; the command is ignored for that cycle.
- Reset asserted mid-operation (e.g. during a load or increment cycle): `value` goes to 0 immediately; the pending operation is discarded.
- Back-to-back loads: each cycle's `load_data_in` is captured independently; the last one wins.

## Test plan
- Reset:
  - drive `rst`=0 with `value`=4'hA, between clock edges → `data_out`=0 immediately, without a clock edge;
  - release `rst`, then idle (2'b10) for 3 cycles → `data_out` stays 0.
- Increment and wrap (`granularity`=4):
  - from 0, drive 2'b01 for 15 cycles → `data_out` steps 1..15, with 4'hF after cycle 15;
  - one more 2'b01 → 0.
- Clear vs. hold:
  - load 4'h7, then 2'b10 for 2 cycles → `data_out` stays 7;
  - 2'b00 for 1 cycle → 0;
  - 2'b11 for 1 cycle with `value`=5 → stays 5.
- Load priority:
  - `value`=3, `load_en`=1, `load_data_in`=4'hC, `sub_command_in`=2'b01 → next cycle `data_out`=4'hC (not 4);
  - with `sub_command_in`=2'b00 instead → also 4'hC.
- Reset mid-load:
  - `load_en`=1 with `load_data_in`=4'h9, and `rst` pulsed low before the edge → `data_out`=0, and still 0 after the edge while `rst`=0.
- Width parameter: instantiate with `granularity`=1 and `granularity`=8:
  - `granularity`=1: increment from 1 → 0;
  - `granularity`=8: increment from 8'hFF → 8'h00;
  - `granularity`=8: load 8'hA5 → 8'hA5 after one cycle.

Source files
------------

// File: rtl/subcounter_if.sv
// subcounter_if: command/load/data bundle between the parent controller and
// one counter slice.
//   sub_command_in : 2-bit command (00 clear, 01 increment, 10/11 hold)
//   load_en        : parallel-load strobe, active-high
//   load_data_in   : parallel-load value
//   data_out       : registered slice value
// Modports: master = parent controller, slave = counter slice.
interface subcounter_if #(
  parameter int unsigned granularity = 4
);
  logic [1:0]             sub_command_in;
  logic                   load_en;
  logic [granularity-1:0] load_data_in;
  logic [granularity-1:0] data_out;

  modport master (
    output sub_command_in,
    output load_en,
    output load_data_in,
    input  data_out
  );

  modport slave (
    input  sub_command_in,
    input  load_en,
    input  load_data_in,
    output data_out
  );
endinterface

// File: rtl/subcounter.sv
// subcounter: single granularity-bit counter slice of the shared counter array.
// Carry, chaining and allocation are handled by the parent; the slice only
// clears, increments (wrapping modulo 2^granularity), holds or loads.
// Ports:
//   clk : clock, all updates on the rising edge
//   rst : asynchronous active-low reset, forces data_out to 0
//   bus : subcounter_if slave (command, load strobe/data, data_out)
// Priority per edge: reset > load > clear > increment > hold.
module subcounter #(
  parameter int unsigned granularity = 4
) (
  input  logic         clk,
  input  logic         rst,
  subcounter_if.slave  bus
);

  logic [granularity-1:0] value;
  logic [granularity-1:0] value_next;

  always_comb begin
    value_next = value;
    if (bus.load_en) begin
      value_next = bus.load_data_in;
    end else begin
      // Anything other than clear/increment (10, 11, or unknown) holds.
      case (bus.sub_command_in)
        2'b00:   value_next = '0;
        2'b01:   value_next = value + 1'b1;
        default: value_next = value;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      value <= '0;
    end else begin
      value <= value_next;
    end
  end

  assign bus.data_out = value;

endmodule

// File: tb/tb_subcounter.sv
// tb_subcounter: directed self-checking bench for subcounter at widths 4, 1
// and 8. Inputs are driven 1 time unit after a rising edge, outputs are
// sampled at the same point (away from the edge).
module tb_subcounter;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  subcounter_if #(.granularity(4)) b4 ();
  subcounter_if #(.granularity(1)) b1 ();
  subcounter_if #(.granularity(8)) b8 ();

  subcounter #(.granularity(4)) dut4 (.clk(clk), .rst(rst), .bus(b4));
  subcounter #(.granularity(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));
  subcounter #(.granularity(8)) dut8 (.clk(clk), .rst(rst), .bus(b8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive4(input logic le, input logic [3:0] d, input logic [1:0] cmd);
    b4.load_en        = le;
    b4.load_data_in   = d;
    b4.sub_command_in = cmd;
  endtask

  task automatic test_reset();
    total++;
    if (b4.data_out !== 4'h0) begin
      bad++;
      $display("FAIL reset_initial: got %h expected %h", b4.data_out, 4'h0);
    end
    rst = 1'b1;
    drive4(1'b1, 4'hA, 2'b10);
    step();
    total++;
    if (b4.data_out !== 4'hA) begin
      bad++;
      $display("FAIL reset_preload: got %h expected %h", b4.data_out, 4'hA);
    end
    drive4(1'b0, 4'h0, 2'b10);
    #2 rst = 1'b0;
    #1;
    total++;
    if (b4.data_out !== 4'h0) begin
      bad++;
      $display("FAIL reset_async: got %h expected %h", b4.data_out, 4'h0);
    end
    #1 rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (b4.data_out !== 4'h0) begin
        bad++;
        $display("FAIL reset_idle%0d: got %h expected %h", i, b4.data_out, 4'h0);
      end
    end
  endtask

  task automatic test_increment();
    drive4(1'b0, 4'h0, 2'b00);
    step();
    drive4(1'b0, 4'h0, 2'b01);
    for (int i = 1; i <= 15; i++) begin
      step();
      total++;
      if (b4.data_out !== 4'(i)) begin
        bad++;
        $display("FAIL inc_step%0d: got %h expected %h", i, b4.data_out, 4'(i));
      end
    end
    step();
    total++;
    if (b4.data_out !== 4'h0) begin
      bad++;
      $display("FAIL inc_wrap: got %h expected %h", b4.data_out, 4'h0);
    end
  endtask

  task automatic test_clear_hold();
    drive4(1'b1, 4'h7, 2'b01);
    step();
    drive4(1'b0, 4'h0, 2'b10);
    for (int i = 0; i < 2; i++) begin
      step();
      total++;
      if (b4.data_out !== 4'h7) begin
        bad++;
        $display("FAIL hold10_%0d: got %h expected %h", i, b4.data_out, 4'h7);
      end
    end
    drive4(1'b0, 4'h0, 2'b00);
    step();
    total++;
    if (b4.data_out !== 4'h0) begin
      bad++;
      $display("FAIL clear: got %h expected %h", b4.data_out, 4'h0);
    end
    drive4(1'b1, 4'h5, 2'b00);
    step();
    drive4(1'b0, 4'h0, 2'b11);
    step();
    total++;
    if (b4.data_out !== 4'h5) begin
      bad++;
      $display("FAIL hold11: got %h expected %h", b4.data_out, 4'h5);
    end
  endtask

  task automatic test_load_priority();
    drive4(1'b1, 4'h3, 2'b10);
    step();
    drive4(1'b1, 4'hC, 2'b01);
    step();
    total++;
    if (b4.data_out !== 4'hC) begin
      bad++;
      $display("FAIL load_over_inc: got %h expected %h", b4.data_out, 4'hC);
    end
    drive4(1'b1, 4'h3, 2'b10);
    step();
    drive4(1'b1, 4'hC, 2'b00);
    step();
    total++;
    if (b4.data_out !== 4'hC) begin
      bad++;
      $display("FAIL load_over_clear: got %h expected %h", b4.data_out, 4'hC);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] vals [3];
    vals[0] = 4'h1;
    vals[1] = 4'hE;
    vals[2] = 4'h6;
    for (int i = 0; i < 3; i++) begin
      drive4(1'b1, vals[i], 2'b01);
      step();
      total++;
      if (b4.data_out !== vals[i]) begin
        bad++;
        $display("FAIL b2b_load%0d: got %h expected %h", i, b4.data_out, vals[i]);
      end
    end
    drive4(1'b0, 4'h0, 2'b01);
    step();
    total++;
    if (b4.data_out !== 4'h7) begin
      bad++;
      $display("FAIL b2b_then_inc: got %h expected %h", b4.data_out, 4'h7);
    end
  endtask

  task automatic test_reset_mid_load();
    drive4(1'b1, 4'h9, 2'b01);
    #2 rst = 1'b0;
    #1;
    total++;
    if (b4.data_out !== 4'h0) begin
      bad++;
      $display("FAIL midload_async: got %h expected %h", b4.data_out, 4'h0);
    end
    step();
    total++;
    if (b4.data_out !== 4'h0) begin
      bad++;
      $display("FAIL midload_edge: got %h expected %h", b4.data_out, 4'h0);
    end
    drive4(1'b0, 4'h0, 2'b10);
    rst = 1'b1;
    step();
    total++;
    if (b4.data_out !== 4'h0) begin
      bad++;
      $display("FAIL midload_release: got %h expected %h", b4.data_out, 4'h0);
    end
  endtask

  task automatic test_widths();
    b1.load_en = 1'b1;
    b1.load_data_in = 1'b1;
    b1.sub_command_in = 2'b10;
    b8.load_en = 1'b1;
    b8.load_data_in = 8'hFF;
    b8.sub_command_in = 2'b10;
    step();
    total++;
    if (b1.data_out !== 1'b1) begin
      bad++;
      $display("FAIL w1_load: got %h expected %h", b1.data_out, 1'b1);
    end
    total++;
    if (b8.data_out !== 8'hFF) begin
      bad++;
      $display("FAIL w8_load_ff: got %h expected %h", b8.data_out, 8'hFF);
    end
    b1.load_en = 1'b0;
    b1.sub_command_in = 2'b01;
    b8.load_en = 1'b0;
    b8.sub_command_in = 2'b01;
    step();
    total++;
    if (b1.data_out !== 1'b0) begin
      bad++;
      $display("FAIL w1_wrap: got %h expected %h", b1.data_out, 1'b0);
    end
    total++;
    if (b8.data_out !== 8'h00) begin
      bad++;
      $display("FAIL w8_wrap: got %h expected %h", b8.data_out, 8'h00);
    end
    b1.sub_command_in = 2'b10;
    b8.load_en = 1'b1;
    b8.load_data_in = 8'hA5;
    b8.sub_command_in = 2'b00;
    step();
    total++;
    if (b8.data_out !== 8'hA5) begin
      bad++;
      $display("FAIL w8_load_a5: got %h expected %h", b8.data_out, 8'hA5);
    end
    b8.load_en = 1'b0;
    b8.sub_command_in = 2'b01;
    step();
    total++;
    if (b8.data_out !== 8'hA6) begin
      bad++;
      $display("FAIL w8_inc: got %h expected %h", b8.data_out, 8'hA6);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b0;
    drive4(1'b0, 4'h0, 2'b10);
    b1.load_en = 1'b0;
    b1.load_data_in = '0;
    b1.sub_command_in = 2'b10;
    b8.load_en = 1'b0;
    b8.load_data_in = '0;
    b8.sub_command_in = 2'b10;
    #1;
    test_reset();
    test_increment();
    test_clear_hold();
    test_load_priority();
    test_back_to_back();
    test_reset_mid_load();
    test_widths();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
